// File: rtl/lustre_activation_ctrl_if.sv
// Signal bundle between the top-level step logic and the activation scheduler.
// The scheduler side uses the slave modport; the step logic (or a bench) uses master.
interface lustre_activation_ctrl_if #(
    parameter int NODES = 4,
    parameter int CNT_W = 16
);
    logic             tick;
    logic [NODES-1:0] active;
    logic [NODES-1:0] restart;
    logic             base_init;
    logic [NODES-1:0] node_en;
    logic [NODES-1:0] node_init;
    logic [NODES-1:0] restart_pend;
    logic [CNT_W-1:0] instant_cnt;

    modport master (
        output tick,
        output active,
        output restart,
        input  base_init,
        input  node_en,
        input  node_init,
        input  restart_pend,
        input  instant_cnt
    );

    modport slave (
        input  tick,
        input  active,
        input  restart,
        output base_init,
        output node_en,
        output node_init,
        output restart_pend,
        output instant_cnt
    );
endinterface

// File: rtl/lustre_activation_ctrl.sv
// Activation scheduler for Lustre temporal operators: per-node enable and first-instant
// (fby init) flags under sub-clocks and restart, plus a global instant counter.
module lustre_activation_ctrl #(
    parameter int NODES = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    lustre_activation_ctrl_if.slave bus,
    output logic [NODES-1:0]       fresh_dbg_o,
    output logic                   base_fresh_dbg_o
);

    // Handshake: there is no back-pressure. An instant is offered when tick=1 and is
    // always consumed on the following posedge; active/restart qualify that instant.

    typedef enum logic {
        BASE_FRESH = 1'b0,
        BASE_RUN   = 1'b1
    } base_state_e;

    typedef enum logic {
        NODE_FRESH = 1'b0,
        NODE_LIVE  = 1'b1
    } node_state_e;

    base_state_e      base_q;
    base_state_e      base_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic [NODES-1:0] fresh_w;
    logic [NODES-1:0] pend_w;
    logic [NODES-1:0] init_w;
    logic [NODES-1:0] en_w;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            base_q <= BASE_FRESH;
            cnt_q  <= '0;
        end else begin
            base_q <= base_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        base_d = base_q;
        cnt_d  = cnt_q;
        if (bus.tick) begin
            base_d = BASE_RUN;
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < NODES; g++) begin : g_node
        node_state_e state_q;
        node_state_e state_d;
        logic        pend_q;
        logic        pend_d;
        logic        hit;

        assign hit = bus.tick & bus.active[g];

        always_ff @(posedge clock_i or posedge reset_i) begin
            if (reset_i) begin
                state_q <= NODE_FRESH;
                pend_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                pend_q  <= pend_d;
            end
        end

        // A restart outside an active instant is remembered until the node next runs;
        // the active instant itself consumes any pending or same-cycle restart.
        always_comb begin
            state_d = state_q;
            pend_d  = pend_q;
            if (state_q == NODE_FRESH && hit) begin
                state_d = NODE_LIVE;
            end
            if (hit) begin
                pend_d = 1'b0;
            end else if (bus.restart[g]) begin
                pend_d = 1'b1;
            end
        end

        assign fresh_w[g] = (state_q == NODE_FRESH);
        assign pend_w[g]  = pend_q;
        assign en_w[g]    = hit & ~reset_i;
        assign init_w[g]  = hit & ~reset_i & (fresh_w[g] | pend_q | bus.restart[g]);
    end

    // Outputs are combinational so fby init can be consumed in the same cycle as tick;
    // reset forces them low even while the step logic is still presenting an instant.
    assign bus.base_init    = bus.tick & (base_q == BASE_FRESH) & ~reset_i;
    assign bus.node_en      = en_w;
    assign bus.node_init    = init_w;
    assign bus.restart_pend = pend_w;
    assign bus.instant_cnt  = cnt_q;

    assign fresh_dbg_o      = fresh_w;
    assign base_fresh_dbg_o = (base_q == BASE_FRESH);

endmodule

// File: tb/tb_lustre_activation_ctrl.sv
// Directed bench for lustre_activation_ctrl with NODES=4 and CNT_W=4 (exercises counter wrap).
module tb_lustre_activation_ctrl;
  localparam int NODES = 4;
  localparam int CNT_W = 4;

  logic clk;
  logic rst;
  logic [NODES-1:0] fresh_dbg;
  logic base_fresh_dbg;
  int checks;
  int errors;
  int exp_cnt;

  lustre_activation_ctrl_if #(.NODES(NODES), .CNT_W(CNT_W)) bus ();

  lustre_activation_ctrl #(.NODES(NODES), .CNT_W(CNT_W)) dut (
    .clock_i          (clk),
    .reset_i          (rst),
    .bus              (bus),
    .fresh_dbg_o      (fresh_dbg),
    .base_fresh_dbg_o (base_fresh_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs away from the posedge; outputs settle 1 time unit later.
  task automatic step(input logic t, input logic [NODES-1:0] a, input logic [NODES-1:0] r);
    @(negedge clk);
    bus.tick = t;
    bus.active = a;
    bus.restart = r;
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic bi, input logic [NODES-1:0] en,
                          input logic [NODES-1:0] ini, input logic [NODES-1:0] pend);
    chk({tag, ".base_init"}, 32'(bus.base_init), 32'(bi));
    chk({tag, ".node_en"}, 32'(bus.node_en), 32'(en));
    chk({tag, ".node_init"}, 32'(bus.node_init), 32'(ini));
    chk({tag, ".restart_pend"}, 32'(bus.restart_pend), 32'(pend));
    chk({tag, ".instant_cnt"}, 32'(bus.instant_cnt), 32'(exp_cnt));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_cnt = 0;
    rst = 1'b1;
    bus.tick = 1'b1;
    bus.active = 4'b1111;
    bus.restart = 4'b1111;
    #12;
    chk_outs("reset_hold", 1'b0, 4'b0000, 4'b0000, 4'b0000);

    // first instant after reset: everything initialises
    step(1'b1, 4'b1111, 4'b0000);
    rst = 1'b0;
    #1;
    chk_outs("first_tick", 1'b1, 4'b1111, 4'b1111, 4'b0000);
    exp_cnt = 1;

    step(1'b1, 4'b1111, 4'b0000);
    chk_outs("second_tick", 1'b0, 4'b1111, 4'b0000, 4'b0000);
    exp_cnt = 2;

    // restart[1] latched with tick=0, survives an inactive tick, consumed on active tick
    step(1'b0, 4'b1111, 4'b0010);
    chk_outs("restart_idle", 1'b0, 4'b0000, 4'b0000, 4'b0000);
    step(1'b1, 4'b1101, 4'b0000);
    chk_outs("pend_inactive", 1'b0, 4'b1101, 4'b0000, 4'b0010);
    exp_cnt = 3;
    step(1'b1, 4'b1111, 4'b0000);
    chk_outs("pend_consume", 1'b0, 4'b1111, 4'b0010, 4'b0010);
    exp_cnt = 4;

    // restart on an active instant is an immediate init, no pend
    step(1'b1, 4'b1111, 4'b0001);
    chk_outs("restart_active", 1'b0, 4'b1111, 4'b0001, 4'b0000);
    exp_cnt = 5;

    // pending restart plus simultaneous restart gives one init and clears pend
    step(1'b0, 4'b0000, 4'b1000);
    chk_outs("restart3_idle", 1'b0, 4'b0000, 4'b0000, 4'b0000);
    step(1'b1, 4'b1111, 4'b1000);
    chk_outs("restart3_simul", 1'b0, 4'b1111, 4'b1000, 4'b1000);
    exp_cnt = 6;

    // restart with tick but node inactive latches pend
    step(1'b1, 4'b1110, 4'b0001);
    chk_outs("restart0_inact", 1'b0, 4'b1110, 4'b0000, 4'b0000);
    exp_cnt = 7;
    step(1'b1, 4'b1111, 4'b0000);
    chk_outs("restart0_consume", 1'b0, 4'b1111, 4'b0001, 4'b0001);
    exp_cnt = 8;

    step(1'b0, 4'b1111, 4'b0000);
    chk_outs("idle_after", 1'b0, 4'b0000, 4'b0000, 4'b0000);

    // counter wrap modulo 16
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 4'b0101, 4'b0000);
      chk_outs("wrap_run", 1'b0, 4'b0101, 4'b0000, 4'b0000);
      exp_cnt = (exp_cnt + 1) % 16;
    end
    step(1'b0, 4'b0000, 4'b0000);
    chk("wrap_zero", 32'(bus.instant_cnt), 32'd1);

    // mid-step async reset with a pending restart outstanding
    step(1'b0, 4'b0000, 4'b0100);
    step(1'b1, 4'b1111, 4'b0000);
    chk("pre_reset.pend", 32'(bus.restart_pend), 32'b0100);
    rst = 1'b1;
    #1;
    exp_cnt = 0;
    chk_outs("mid_reset", 1'b0, 4'b0000, 4'b0000, 4'b0000);

    // fresh again: node 2 stays fresh through 5 inactive ticks
    step(1'b1, 4'b1011, 4'b0000);
    rst = 1'b0;
    #1;
    chk_outs("post_reset", 1'b1, 4'b1011, 4'b1011, 4'b0000);
    exp_cnt = 1;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'b1011, 4'b0000);
      chk_outs("node2_idle", 1'b0, 4'b1011, 4'b0000, 4'b0000);
      exp_cnt = exp_cnt + 1;
    end
    step(1'b1, 4'b1111, 4'b0000);
    chk_outs("node2_first", 1'b0, 4'b1111, 4'b0100, 4'b0000);
    exp_cnt = exp_cnt + 1;
    step(1'b1, 4'b1111, 4'b0000);
    chk_outs("node2_live", 1'b0, 4'b1111, 4'b0000, 4'b0000);

    step(1'b0, 4'b0000, 4'b0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
